// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// skewed operands in, deskewed sum out, valid/ready stream with full-pipe stall.
module pipelined_cla_addsub #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / BLOCK;

   if ((WIDTH % BLOCK) != 0 || BLOCK < 2) begin : g_bad_param
      $fatal(1, "pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
   end

   // Every carry is a flat sum-of-products of p, g and the group carry-in.
   function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] p,
                                          input logic [BLOCK-1:0] g,
                                          input logic             ci);
      logic [BLOCK:0] c;
      logic           t;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLOCK; i++) begin
         t = ci;
         for (int j = 0; j <= i; j++) t = t & p[j];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return c;
   endfunction

   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;
   logic             w_adv;

   assign w_b_eff  = sub ? ~b : b;
   assign w_c0     = sub | cin;
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int SW = WIDTH - k * BLOCK;   // operand bits not yet resolved
      localparam int LW = k * BLOCK;           // result bits already resolved

      logic [SW-1:0]       w_a_in;
      logic [SW-1:0]       w_b_in;
      logic                w_c_in;
      logic                w_v_in;
      logic [BLOCK-1:0]    w_p;
      logic [BLOCK-1:0]    w_g;
      logic [BLOCK-1:0]    w_s;
      logic [BLOCK:0]      w_c;
      logic [LW+BLOCK-1:0] w_s_nxt;
      logic [LW+BLOCK-1:0] r_s;
      logic                r_c;
      logic                r_v;

      if (k == 0) begin : g_src
         assign w_a_in  = a;
         assign w_b_in  = w_b_eff;
         assign w_c_in  = w_c0;
         assign w_v_in  = in_valid;
         assign w_s_nxt = w_s;
      end else begin : g_src
         assign w_a_in  = g_stg[k-1].g_skew.r_a;
         assign w_b_in  = g_stg[k-1].g_skew.r_b;
         assign w_c_in  = g_stg[k-1].r_c;
         assign w_v_in  = g_stg[k-1].r_v;
         assign w_s_nxt = {w_s, g_stg[k-1].r_s};
      end

      assign w_p = w_a_in[BLOCK-1:0] ^ w_b_in[BLOCK-1:0];
      assign w_g = w_a_in[BLOCK-1:0] & w_b_in[BLOCK-1:0];
      assign w_c = cla(w_p, w_g, w_c_in);
      assign w_s = w_p ^ w_c[BLOCK-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s <= '0;
            r_c <= 1'b0;
            r_v <= 1'b0;
         end else if (w_adv) begin
            r_s <= w_s_nxt;
            r_c <= w_c[BLOCK];
            r_v <= w_v_in;
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [SW-BLOCK-1:0] r_a;
         logic [SW-BLOCK-1:0] r_b;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a_in[SW-1:BLOCK];
               r_b <= w_b_in[SW-1:BLOCK];
            end
         end
      end

      if (k == STAGES - 1) begin : g_ovf
         logic r_o;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     r_o <= 1'b0;
            else if (w_adv) r_o <= w_c[BLOCK] ^ w_c[BLOCK-1];
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].r_v;
   assign sum       = g_stg[STAGES-1].r_s;
   assign cout      = g_stg[STAGES-1].r_c;
   assign ovf       = g_stg[STAGES-1].g_ovf.r_o;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub at WIDTH=16, BLOCK=4 (four-stage pipe).
module tb_pipelined_cla_addsub;

   localparam int W   = 16;
   localparam int B   = 4;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, sum;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rmode  = 0;   // 0: always ready, 1: random ready, 2: stalled

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t q[$];
   exp_t e_mon;

   pipelined_cla_addsub #(.WIDTH(W), .BLOCK(B)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic ic, input logic is);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   f;
      be   = is ? ~ib : ib;
      f    = {1'b0, ia} + {1'b0, be} + {{W{1'b0}}, (is | ic)};
      e.s  = f[W-1:0];
      e.co = f[W];
      e.ov = (ia[W-1] == be[W-1]) && (f[W-1] != ia[W-1]);
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
      exp_t e;
      e.s = s; e.co = co; e.ov = ov; e.acc = 0; e.lat = 1'b0;
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   endtask

   task automatic send_e(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is, input exp_t e);
      int n;
      exp_t x;
      tick();
      a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         #1;
         n++;
      end
      check("accept_timeout", 32'(in_ready), 32'd1);
      x     = e;
      x.acc = cyc;
      x.lat = (rmode == 0);
      q.push_back(x);
   endtask

   task automatic send_m(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is);
      send_e(ia, ib, ic, is, model(ia, ib, ic, is));
   endtask

   task automatic send_k(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is,
                         input logic [W-1:0] s, input logic co, input logic ov);
      send_e(ia, ib, ic, is, mk(s, co, ov));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         tick();
         in_valid = 1'b0;
         n++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      #2;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         check("beat_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e_mon = q.pop_front();
            check("sum",  32'(sum),  32'(e_mon.s));
            check("cout", 32'(cout), 32'(e_mon.co));
            check("ovf",  32'(ovf),  32'(e_mon.ov));
            if (e_mon.lat) check("latency", 32'(cyc - e_mon.acc), 32'(LAT));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum",       32'(sum),       32'd0);
      check("rst_cout",      32'(cout),      32'd0);
      check("rst_ovf",       32'(ovf),       32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases with hand-derived results
      rmode = 0;
      send_k(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send_k(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
      send_k(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send_k(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send_k(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send_k(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      send_k(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      send_k(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
      send_k(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      drain();

      // Back-to-back random beats, always ready
      for (int i = 0; i < 64; i++)
         send_m(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();

      // Fill the pipe against a stalled sink, then hold for 5 cycles
      rmode = 2;
      for (int i = 0; i < LAT; i++)
         send_m(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 5; i++) begin
         tick();
         a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
         #1;
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready",  32'(in_ready),  32'd0);
         check("stall_sum",       32'(sum),       32'(q[0].s));
         check("stall_cout",      32'(cout),      32'(q[0].co));
         check("stall_ovf",       32'(ovf),       32'(q[0].ov));
      end
      rmode = 0;
      send_m(16'h4321, 16'h1111, 1'b0, 1'b1);
      drain();

      // Random backpressure across 200 beats
      rmode = 1;
      for (int i = 0; i < 200; i++)
         send_m(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain();

      // Asynchronous reset with three beats in flight
      rmode = 2;
      for (int i = 0; i < 3; i++)
         send_m(16'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      tick();
      in_valid = 1'b0;
      tick();
      #1;
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      check("pre_rst_sum",       32'(sum),       32'(q[0].s));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum",       32'(sum),       32'd0);
      check("midrst_cout",      32'(cout),      32'd0);
      check("midrst_ovf",       32'(ovf),       32'd0);
      q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      rmode = 0;
      send_m(16'h00F0, 16'h0F10, 1'b0, 1'b0);
      drain();
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into BLOCK-bit lookahead groups, with one group resolved per pipeline stage. Each stage computes group propagate/generate and lookahead carries internally, then registers the group carry into the next stage. It serves as the datapath adder for wider ALU work, with a valid/ready stream on both sides, full throughput and backpressure.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of BLOCK.
BLOCK, 8, bits per lookahead group; must be at least 2. STAGES = WIDTH/BLOCK is the pipeline depth.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts an operand beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; for sub this is the not-borrow flag
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset: all stage valid bits clear; out_valid=0; sum, cout and ovf read 0. Reset mid-operation discards every in-flight beat, and no partial result is ever presented.
- Operand handling: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. Per bit: p = a^b_eff, g = a&b_eff.
- Group carries: within a group, carries use full lookahead equations with no ripple through the group: c[i+1] = g[i] | p[i]&c[i], expanded to sum-of-products of the group's p, g and incoming carry.
- Stage k (0..STAGES-1): resolves group k using the carry registered from stage k-1 (c0 for stage 0).
  - Upper operand groups travel through skew registers until their stage.
  - Lower result groups travel through deskew registers, so all WIDTH bits of sum emerge together.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1 when there is no stall. Throughput is one beat per cycle.
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When adv=1, every stage register (data and valid) shifts one stage. Bubbles propagate as valid=0 entries.
  - When adv=0, all stages hold, and sum, cout, ovf and out_valid stay stable until out_ready.
  - in_ready depends combinationally on out_ready. No internal bubble squeezing.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Both flags are registered with sum in the final stage.
- Wrap-around: sum is modulo 2^WIDTH; no saturation.
- Transfer timing: simultaneous accept and output transfer in the same cycle is legal and loses nothing.
- Mode: sub and cin are captured per beat. Mixed add/sub streams are independent.
- Elaboration: WIDTH % BLOCK != 0 or BLOCK < 2 is a fatal elaboration error.

Test Plan:
(bench uses WIDTH=16, BLOCK=4; latency 4)
- Add with carry-out: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0. Same with cin=1 -> sum=0x0001, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Carry chain across all groups: a=0x0FFF, b=0x0001 -> sum=0x1000.
- Throughput: 64 random back-to-back beats with out_ready=1 -> 64 results in order, one per cycle, the first 4 cycles after the first accept, all matching the reference model (a±b, flags).
- Backpressure: hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, sum and flags stable, no beats lost or duplicated. Toggle out_ready randomly across 200 beats -> results in order, scoreboard clean.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 beats in flight -> out_valid=0 and sum=0 immediately. After release, the first new beat emerges 4 cycles after accept and no stale beat appears.
